stepper_phase_decoder: RTL and testbench
========================================

# stepper_phase_decoder

Monitors the 4-bit half-step coil drive bus from the stepper controller (or any external driver using the same 8-phase half-step sequence). It recovers phase index, step direction and a signed step position, and flags skipped or illegal coil patterns. Sits beside the controller as a closed-loop position tracker and drive-integrity checker.

## Interface
- POS_W, 16, width of signed position counter (min 4)
- STABLE_CYCLES, 4, consecutive cycles a pattern must hold before acceptance (1–255)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coil_in  in  4  coil drive pattern being monitored
- clear  in  1  synchronous clear: position→0, fault cleared, state→UNLOCKED
- position  out  POS_W  signed step count, two's complement
- dir  out  1  direction of last accepted step (1 = forward/+1)
- step_pulse  out  1  one-cycle pulse per accepted ±1 step
- phase_idx  out  3  current phase index 0–7
- locked  out  1  a valid phase reference is held
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 skipped phase, 10 illegal pattern, 11 reserved

## Operation
- Phase table, index→pattern: 0:0001 1:0011 2:0010 3:0110 4:0100 5:1100 6:1000 7:1001. 0000 = IDLE (coils off). All other 7 patterns are illegal.
- coil_in passes through a 2-flop synchronizer, then a stability filter: a candidate is accepted once it has been held unchanged for STABLE_CYCLES consecutive cycles. Any change restarts the count. Each stable pattern is accepted exactly once.
- FSM states: UNLOCKED, LOCKED, FAULT.
- UNLOCKED: accepted valid phase → phase_idx = index, locked=1, → LOCKED, no step. Accepted IDLE → stay. Accepted illegal → fault_code 10, → FAULT.
- LOCKED, accepted valid phase: delta = (new − phase_idx) mod 8.
  - 1 → position+1, dir=1, step_pulse.
  - 7 → position−1, dir=0, step_pulse.
  - 0 → no change.
  - 2–6 → fault_code 01, → FAULT; phase_idx and position unchanged.
- LOCKED, accepted IDLE: hold phase_idx, stay LOCKED; the next phase is judged against the held index.
- LOCKED, accepted illegal: fault_code 10, → FAULT.
- FAULT: fault=1, locked=0, position/phase_idx frozen, no step_pulse. Exit only via clear or reset.
- position wraps modulo 2^POS_W; wrap is not a fault.
- clear (any state) → position=0, fault=0, fault_code=00, locked=0, dir=0, phase_idx=0, UNLOCKED. The filter restarts, so the current pattern must be re-accepted before locking.
- clear coincident with an acceptance: clear wins, the acceptance is discarded.

## Timing
- Reset (asynchronous, immediate): position=0, dir=0, step_pulse=0, phase_idx=0, locked=0, fault=0, fault_code=00. Synchronizer/filter cleared, state UNLOCKED.
- Latency with filter: outputs update STABLE_CYCLES+3 rising edges after the first edge sampling the new coil_in value. Default value: 7.
- Latency without filter: 3 edges.
- step_pulse high exactly one cycle, coincident with the position update.
- Maximum tracked step rate: one step per STABLE_CYCLES+1 cycles. Faster patterns are filtered out and may yield a skip fault.
- Reset deasserted mid-pattern: behaves as a fresh UNLOCKED start.

## Configuration
- STEPPER_DEC_FILTER_EN defined: stability filter active as above.
- STEPPER_DEC_FILTER_EN undefined: filter removed. Every synchronized pattern change is accepted the cycle it appears, STABLE_CYCLES is ignored, latency is 3.

## Test plan
- Reset, then drive 0001 held → locked=1 at edge 7, phase_idx=0, position=0, no step_pulse.
- Forward sequence 0001→0011→…→1001→0001, each held 8 cycles → 8 step_pulses, dir=1, position=8, phase_idx=0.
- From position 8, reverse 0001→1001→1000 → position=6, dir=0.
- Glitch: 0011 for 3 cycles inside a 0001 hold → no step, position unchanged. Then 0001→0010 (skip) → fault=1, fault_code=01, position frozen. Then clear → fault=0, position=0, relock on 0010.
- Drive 0101 → fault_code=10. POS_W=4: 8 forward steps from 7 → position wraps to −1 (4'hF), no fault.
- IDLE between phases: 0110→0000→0100 → one +1 step. Assert reset mid-stream → all outputs zero immediately.

Source files
------------

// File: rtl/stepper_phase_decoder.sv
// rtl/stepper_phase_decoder.sv - half-step coil bus monitor: phase, direction, position, faults.
// Define STEPPER_DEC_FILTER_EN to insert the STABLE_CYCLES stability filter after the synchronizer.
module stepper_phase_decoder #(
  parameter int POS_W         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       coil_in,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             step_pulse,
  output logic [2:0]       phase_idx,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [1:0] {S_UNLOCKED, S_LOCKED, S_FAULT} state_t;

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || POS_W < 4) begin : g_bad_cfg
    $error("stepper_phase_decoder: unsupported parameter values");
  end

  logic [3:0] sync1, sync2;
  logic       acc;
  logic [3:0] acc_pat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= coil_in;
      sync2 <= sync1;
    end
  end

`ifdef STEPPER_DEC_FILTER_EN
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  logic [3:0] cand;
  logic [7:0] cnt;
  logic       done;

  // done blocks re-acceptance of a candidate that simply keeps holding
  assign acc     = (cnt == STABLE) && !done;
  assign acc_pat = cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (clear) begin
      cand <= sync2;
      cnt  <= '0;
      done <= 1'b0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= 8'd1;
      done <= 1'b0;
    end else begin
      if (cnt != STABLE) cnt <= cnt + 8'd1;
      if (acc) done <= 1'b1;
    end
  end
`else
  logic [3:0] prev;
  logic       pend;

  // pend forces re-acceptance of the held pattern on the cycle after a clear
  assign acc     = pend || (sync2 != prev);
  assign acc_pat = sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= '0;
      pend <= 1'b0;
    end else begin
      prev <= sync2;
      pend <= clear;
    end
  end
`endif

  logic       pat_valid, pat_idle;
  logic [2:0] pat_idx;

  always_comb begin
    pat_valid = 1'b1;
    pat_idle  = 1'b0;
    pat_idx   = 3'd0;
    case (acc_pat)
      4'b0001: pat_idx = 3'd0;
      4'b0011: pat_idx = 3'd1;
      4'b0010: pat_idx = 3'd2;
      4'b0110: pat_idx = 3'd3;
      4'b0100: pat_idx = 3'd4;
      4'b1100: pat_idx = 3'd5;
      4'b1000: pat_idx = 3'd6;
      4'b1001: pat_idx = 3'd7;
      4'b0000: begin pat_valid = 1'b0; pat_idle = 1'b1; end
      default: pat_valid = 1'b0;
    endcase
  end

  state_t           state, state_n;
  logic [POS_W-1:0] pos_n;
  logic             dir_n, step_n;
  logic [2:0]       idx_n, delta;
  logic [1:0]       code_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_UNLOCKED;
      position   <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      phase_idx  <= '0;
      fault_code <= '0;
    end else begin
      state      <= state_n;
      position   <= pos_n;
      dir        <= dir_n;
      step_pulse <= step_n;
      phase_idx  <= idx_n;
      fault_code <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = position;
    dir_n   = dir;
    step_n  = 1'b0;
    idx_n   = phase_idx;
    code_n  = fault_code;
    delta   = pat_idx - phase_idx;
    if (clear) begin
      state_n = S_UNLOCKED;
      pos_n   = '0;
      dir_n   = 1'b0;
      idx_n   = '0;
      code_n  = 2'b00;
    end else if (acc) begin
      case (state)
        S_UNLOCKED: begin
          if (pat_valid) begin
            idx_n   = pat_idx;
            state_n = S_LOCKED;
          end else if (!pat_idle) begin
            code_n  = 2'b10;
            state_n = S_FAULT;
          end
        end
        S_LOCKED: begin
          if (pat_valid) begin
            if (delta == 3'd1) begin
              pos_n  = position + POS_ONE;
              dir_n  = 1'b1;
              step_n = 1'b1;
              idx_n  = pat_idx;
            end else if (delta == 3'd7) begin
              pos_n  = position - POS_ONE;
              dir_n  = 1'b0;
              step_n = 1'b1;
              idx_n  = pat_idx;
            end else if (delta != 3'd0) begin
              code_n  = 2'b01;
              state_n = S_FAULT;
            end
          end else if (!pat_idle) begin
            code_n  = 2'b10;
            state_n = S_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

  assign locked = (state == S_LOCKED);
  assign fault  = (state == S_FAULT);

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb/tb_stepper_phase_decoder.sv - scoreboard bench for stepper_phase_decoder.
module tb_stepper_phase_decoder;

`ifdef STEPPER_DEC_FILTER_EN
  localparam int LAT    = 7;
  localparam bit GL_DIR = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit GL_DIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        clear4 = 1'b0;
  logic [3:0]  coil = 4'b0000;
  logic [3:0]  coil4 = 4'b0000;

  logic [15:0] position;
  logic        dir, step_pulse, locked, fault;
  logic [2:0]  phase_idx;
  logic [1:0]  fault_code;

  logic [3:0]  position4;
  logic        dir4, step_pulse4, locked4, fault4;
  logic [2:0]  phase_idx4;
  logic [1:0]  fault_code4;

  stepper_phase_decoder #(.POS_W(16), .STABLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .coil_in(coil), .clear(clear),
    .position(position), .dir(dir), .step_pulse(step_pulse), .phase_idx(phase_idx),
    .locked(locked), .fault(fault), .fault_code(fault_code)
  );

  stepper_phase_decoder #(.POS_W(4), .STABLE_CYCLES(4)) u_w4 (
    .clk(clk), .reset(reset), .coil_in(coil4), .clear(clear4),
    .position(position4), .dir(dir4), .step_pulse(step_pulse4), .phase_idx(phase_idx4),
    .locked(locked4), .fault(fault4), .fault_code(fault_code4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;
    logic        sp;
    logic [2:0]  idx;
    logic        lk;
    logic        flt;
    logic [1:0]  code;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_exp, mon_got;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_flags = 4'b0000;
  logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int pos, input bit d, input bit sp, input int idx,
                           input bit lk, input bit flt, input int code);
    ev_t e;
    e.pos  = 16'(pos);
    e.dir  = d;
    e.sp   = sp;
    e.idx  = 3'(idx);
    e.lk   = lk;
    e.flt  = flt;
    e.code = 2'(code);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] p, input int n);
    @(negedge clk);
    coil = p;
    repeat (n) @(posedge clk);
  endtask

  task automatic drive4(input logic [3:0] p, input int n);
    @(negedge clk);
    coil4 = p;
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: every step pulse or status-flag change is an output event
  always @(negedge clk) begin
    if (mon_en && (step_pulse || ({locked, fault, fault_code} != prev_flags))) begin
      n_checks++;
      mon_got = {position, dir, step_pulse, phase_idx, locked, fault, fault_code};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %0h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
          begin
            n_fail++;
            $display("FAIL event: got pos=%0d dir=%0d sp=%0d idx=%0d lk=%0d flt=%0d code=%0d required pos=%0d dir=%0d sp=%0d idx=%0d lk=%0d flt=%0d code=%0d",
                     mon_got.pos, mon_got.dir, mon_got.sp, mon_got.idx, mon_got.lk, mon_got.flt, mon_got.code,
                     mon_exp.pos, mon_exp.dir, mon_exp.sp, mon_exp.idx, mon_exp.lk, mon_exp.flt, mon_exp.code);
          end
      end
    end
    prev_flags = {locked, fault, fault_code};
  end

  initial begin
    #3 reset = 1'b0;
    #1;
    check("reset_position", 32'(position), 0);
    check("reset_flags", {28'd0, dir, step_pulse, locked, fault}, 0);
    check("reset_idx_code", {27'd0, phase_idx, fault_code}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk) mon_en = 1'b1;

    // Lock on phase 0 with latency check
    expect_ev(0, 0, 0, 0, 1, 0, 0);
    drive(4'b0001, LAT - 1);
    #1 check("lock_before_latency", 32'(locked), 0);
    @(posedge clk);
    #1 check("lock_at_latency", 32'(locked), 1);
    repeat (4) @(posedge clk);

    for (int i = 1; i <= 8; i++) begin
      expect_ev(i, 1, 1, i % 8, 1, 0, 0);
      drive(tbl[i % 8], 8);
    end
    check("fwd_position", 32'(position), 8);

    expect_ev(7, 0, 1, 7, 1, 0, 0);
    drive(tbl[7], 8);
    expect_ev(6, 0, 1, 6, 1, 0, 0);
    drive(tbl[6], 8);
    check("rev_position", 32'(position), 6);
    check("rev_dir", 32'(dir), 0);

    expect_ev(7, 1, 1, 7, 1, 0, 0);
    drive(tbl[7], 8);
    expect_ev(8, 1, 1, 0, 1, 0, 0);
    drive(tbl[0], 8);

    // Short glitch: filtered out when the stability filter is present
`ifndef STEPPER_DEC_FILTER_EN
    expect_ev(9, 1, 1, 1, 1, 0, 0);
    expect_ev(8, 0, 1, 0, 1, 0, 0);
`endif
    drive(4'b0011, 3);
    drive(4'b0001, 8);
    check("glitch_position", 32'(position), 8);

    expect_ev(8, GL_DIR, 0, 0, 0, 1, 1);
    drive(4'b0010, 8);
    check("skip_fault_code", {30'd0, fault_code}, 1);
    check("skip_position_frozen", 32'(position), 8);

    expect_ev(0, 0, 0, 0, 0, 0, 0);
    expect_ev(0, 0, 0, 2, 1, 0, 0);
    pulse_clear();
    repeat (12) @(posedge clk);
    #1 check("relock_idx", 32'(phase_idx), 2);

    expect_ev(0, 0, 0, 2, 0, 1, 2);
    drive(4'b0101, 8);
    check("illegal_code", {30'd0, fault_code}, 2);

    drive(4'b0000, 8);
    expect_ev(0, 0, 0, 0, 0, 0, 0);
    pulse_clear();
    repeat (10) @(posedge clk);

    expect_ev(0, 0, 0, 3, 1, 0, 0);
    drive(4'b0110, 8);
    drive(4'b0000, 8);
    expect_ev(1, 1, 1, 4, 1, 0, 0);
    drive(4'b0100, 8);
    check("idle_gap_position", 32'(position), 1);
    check("queue_drained_before_reset", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-stream
    drive(4'b1100, 2);
    #2 mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midreset_position", 32'(position), 0);
    check("midreset_flags", {28'd0, dir, step_pulse, locked, fault}, 0);
    check("midreset_idx_code", {27'd0, phase_idx, fault_code}, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) mon_en = 1'b1;
    expect_ev(0, 0, 0, 5, 1, 0, 0);
    repeat (12) @(posedge clk);

    // Narrow counter: wraps from +7 through to -1 without fault
    drive4(tbl[0], 8);
    for (int i = 1; i <= 15; i++) begin
      drive4(tbl[i % 8], 8);
      if (i == 7) check("w4_position_7", 32'(position4), 7);
    end
    check("w4_position_wrap", 32'(position4), 32'hF);
    check("w4_no_fault", {30'd0, fault4, locked4}, 1);

    repeat (10) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
